// File: rtl/q11_pkg.sv
`default_nettype none
// ============================================================================
// Module  : q11_pkg
// Brief   : Shared types for the q11 "1010" sequence detector.
// Rev     : 1.0 - initial release
// ============================================================================
package q11_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S0 = 4'b0000;
  localparam state_t S1 = 4'b0001;
  localparam state_t S2 = 4'b0010;
  localparam state_t S3 = 4'b0011;
  localparam state_t S4 = 4'b0100;

  typedef enum logic [1:0] {
    SYM_NONE = 2'd0,
    SYM_ONE  = 2'd1,
    SYM_ZERO = 2'd2,
    SYM_BAD  = 2'd3
  } sym_e;

endpackage : q11_pkg
`default_nettype wire

// File: rtl/q11_if.sv
`default_nettype none
// ============================================================================
// Module  : q11_if
// Brief   : Symbol strobes in, state/detect flag out for the q11 detector.
// Rev     : 1.0 - initial release
// ============================================================================
interface q11_if;

  logic       ONE;
  logic       ZERO;
  logic [3:0] state;
  logic       out;

  modport master (output ONE, output ZERO, input state, input out);
  modport slave  (input ONE, input ZERO, output state, output out);

endinterface : q11_if
`default_nettype wire

// File: rtl/q11_sym_decode.sv
`default_nettype none
// ============================================================================
// Module  : q11_sym_decode
// Brief   : Maps the one-hot ONE/ZERO strobes onto a symbol code.
// Rev     : 1.0 - initial release
// ============================================================================
module q11_sym_decode
  import q11_pkg::*;
(
  input  wire logic i_one,
  input  wire logic i_zero,
  output sym_e      o_sym
);

  always_comb begin
    case ({i_one, i_zero})
      2'b10:   o_sym = SYM_ONE;
      2'b01:   o_sym = SYM_ZERO;
      2'b11:   o_sym = SYM_BAD;
      default: o_sym = SYM_NONE;
    endcase
  end

endmodule : q11_sym_decode
`default_nettype wire

// File: rtl/q11.sv
`default_nettype none
// ============================================================================
// Module  : q11
// Brief   : Moore detector for the overlapping symbol sequence 1,0,1,0.
// Rev     : 1.0 - initial release
// ============================================================================
module q11
  import q11_pkg::*;
(
  input  wire logic clk,
  input  wire logic reset,
  q11_if.slave      bus
);

  sym_e   w_sym;
  state_t r_state;
  state_t w_next;

  q11_sym_decode u_sym_decode (
    .i_one  (bus.ONE),
    .i_zero (bus.ZERO),
    .o_sym  (w_sym)
  );

  // Unused encodings and the illegal both-high strobe fall through to S0.
  always_comb begin
    w_next = S0;
    case (r_state)
      S0, S1, S2, S3, S4: begin
        case (w_sym)
          SYM_NONE: w_next = r_state;
          SYM_ONE: begin
            case (r_state)
              S2, S4:  w_next = S3;
              default: w_next = S1;
            endcase
          end
          SYM_ZERO: begin
            case (r_state)
              S1:      w_next = S2;
              S3:      w_next = S4;
              default: w_next = S0;
            endcase
          end
          default: w_next = S0;
        endcase
      end
      default: w_next = S0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S0;
    end else begin
      r_state <= w_next;
    end
  end

  assign bus.state = r_state;
  assign bus.out   = (r_state == S4);

endmodule : q11
`default_nettype wire

// File: tb/tb_q11.sv
`default_nettype none
// ============================================================================
// Module  : tb_q11
// Brief   : Self-checking bench for q11 against a suffix-match reference.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_q11;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  bit   started = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  q11_if bus ();

  q11 u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: the state is the length of the longest suffix of the symbol
  // history (since reset or an illegal strobe) that is a prefix of 1,0,1,0.
  logic [3:0] m_hist = 4'b0000;
  int         m_len  = 0;
  logic [3:0] exp_state;

  function automatic logic [3:0] f_match(logic [3:0] h, int len);
    logic [3:0] pat = 4'b1010;
    logic [3:0] best = 4'd0;
    bit ok;
    for (int k = 1; k <= 4; k++) begin
      if (k <= len) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++)
          if (h[k-1-i] != pat[3-i]) ok = 1'b0;
        if (ok) best = 4'(k);
      end
    end
    return best;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_len <= 0;
    end else if (bus.ONE && bus.ZERO) begin
      m_len <= 0;
    end else if (bus.ONE ^ bus.ZERO) begin
      m_hist <= {m_hist[2:0], bus.ONE};
      m_len  <= (m_len < 4) ? m_len + 1 : 4;
    end
  end

  always_comb exp_state = f_match(m_hist, m_len);

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("model_state", bus.state, exp_state);
      check("model_out", {3'b000, bus.out}, {3'b000, exp_state == 4'd4});
    end
  end

  task automatic drive(input logic one, input logic zero);
    @(negedge clk);
    bus.ONE  = one;
    bus.ZERO = zero;
  endtask

  task automatic step_chk(input logic one, input logic zero, input logic [3:0] want, input string name);
    drive(one, zero);
    @(posedge clk);
    #1;
    check({name, "_state"}, bus.state, want);
    check({name, "_out"}, {3'b000, bus.out}, {3'b000, want == 4'd4});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 reset = 1'b0;
    #1 check("async_reset", bus.state, 4'b0000);
    check("async_reset_out", {3'b000, bus.out}, 4'b0000);
    reset = 1'b1;
  endtask

  initial begin
    int r;
    bus.ONE  = 1'b0;
    bus.ZERO = 1'b0;
    #2 reset = 1'b0;
    started = 1'b1;

    // Held reset with random strobes
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom), 1'($urandom));
      @(posedge clk);
      #1 check("reset_hold", bus.state, 4'b0000);
    end
    @(negedge clk);
    reset = 1'b1;

    step_chk(1, 0, 4'b0001, "det1");
    step_chk(0, 1, 4'b0010, "det2");
    step_chk(1, 0, 4'b0011, "det3");
    step_chk(0, 1, 4'b0100, "det4");
    step_chk(1, 0, 4'b0011, "ovl1");
    step_chk(0, 1, 4'b0100, "ovl2");
    step_chk(0, 1, 4'b0000, "brk0");
    step_chk(1, 0, 4'b0001, "brkA1");
    step_chk(0, 1, 4'b0010, "brkA2");
    step_chk(0, 1, 4'b0000, "brkA3");
    step_chk(1, 0, 4'b0001, "brkB1");
    step_chk(1, 0, 4'b0001, "brkB2");
    step_chk(0, 1, 4'b0010, "brkB3");
    step_chk(1, 0, 4'b0011, "brkB4");
    step_chk(0, 1, 4'b0100, "brkB5");
    step_chk(1, 0, 4'b0011, "to_s3");
    for (int i = 0; i < 3; i++) step_chk(0, 0, 4'b0011, "idle");
    step_chk(1, 1, 4'b0000, "illegal");
    step_chk(1, 0, 4'b0001, "mid1");
    step_chk(0, 1, 4'b0010, "mid2");
    step_chk(1, 0, 4'b0011, "mid3");
    bus.ONE = 1'b0;
    pulse_reset();
    step_chk(0, 1, 4'b0000, "mid_after");

    // Random phase: mostly legal symbols, some idles, rare illegal/reset
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        pulse_reset();
        r = $urandom_range(2, 99);
      end else begin
        @(negedge clk);
      end
      if (r < 47)      begin bus.ONE = 1'b1; bus.ZERO = 1'b0; end
      else if (r < 88) begin bus.ONE = 1'b0; bus.ZERO = 1'b1; end
      else if (r < 96) begin bus.ONE = 1'b0; bus.ZERO = 1'b0; end
      else             begin bus.ONE = 1'b1; bus.ZERO = 1'b1; end
    end

    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_q11
`default_nettype wire
